// File: rtl/prog_mem_responder_pkg.sv
// Shared types and constants for the accumulator-core program store.
// Holds opcode encodings, responder states and the default boot program.
package prog_mem_responder_pkg;

    localparam logic [5:0] OP_NOP  = 6'd0;
    localparam logic [5:0] OP_ADD  = 6'd1;
    localparam logic [5:0] OP_SWAP = 6'd2;
    localparam logic [5:0] OP_JMP  = 6'd3;
    localparam logic [5:0] OP_JNZ  = 6'd4;

    typedef enum logic {
        SERVE = 1'b0,
        LOAD  = 1'b1
    } state_e;

    localparam int DEF_LEN = 4;

    // add, swap, jump 0: reg_a walks the Fibonacci sequence
    localparam logic [5:0] DEF_PROG [0:DEF_LEN-1] = '{
        OP_ADD, OP_SWAP, OP_JMP, 6'd0
    };

    function automatic logic [5:0] def_word(input int idx);
        logic [5:0] w;
        w = OP_NOP;
        for (int k = 0; k < DEF_LEN; k++) begin
            if (idx == k) w = DEF_PROG[k];
        end
        return w;
    endfunction

endpackage

// File: rtl/prog_mem_responder_store.sv
// DEPTH x 6 register-file program store: async read, sync write,
// synchronous reload of the default program.
module prog_store_rf
    import prog_mem_responder_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          load_def,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [5:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [5:0]    rdata
);

    logic [5:0] mem_q [DEPTH];
    logic [5:0] mem_d [DEPTH];

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (we) mem_d[waddr] = wdata;
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (load_def) mem_q[i] <= def_word(i);
            else          mem_q[i] <= mem_d[i];
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/prog_mem_responder.sv
// Fetch-side program memory for the 6-bit accumulator core, with a
// valid/ready host port for reloading the store.
module prog_mem_responder
    import prog_mem_responder_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  mem_request,
    output logic [5:0]  mem_data,
    input  logic        load_en,
    input  logic        load_valid,
    input  logic [5:0]  load_data,
    output logic        load_ready,
    output logic        load_full,
    output logic [AW:0] load_count
);

    localparam logic [AW:0] CNT_LAST = (AW+1)'(DEPTH - 1);
    localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);

    state_e        state_q, state_d;
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW:0]   count_q, count_d;
    logic          full_q, full_d;
    logic          we;
    logic          hit;
    logic [5:0]    rdata;

    assign load_ready = (state_q == LOAD) && !full_q;

    always_comb begin
        state_d = state_q;
        wptr_d  = wptr_q;
        count_d = count_q;
        full_d  = full_q;
        we      = 1'b0;
        unique case (state_q)
            SERVE: begin
                if (load_en) begin
                    state_d = LOAD;
                    wptr_d  = '0;
                    count_d = '0;
                    full_d  = 1'b0;
                end
            end
            LOAD: begin
                if (load_valid && load_ready) begin
                    we      = 1'b1;
                    wptr_d  = wptr_q + 1'b1;
                    count_d = count_q + CNT_ONE;
                    full_d  = (count_q == CNT_LAST);
                end
                if (!load_en) state_d = SERVE;
            end
            default: state_d = SERVE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= SERVE;
            wptr_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
            full_q  <= full_d;
        end
    end

    prog_store_rf #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_store (
        .clk      (clk),
        .load_def (!reset),
        .we       (we),
        .waddr    (wptr_q),
        .wdata    (load_data),
        .raddr    (mem_request[AW-1:0]),
        .rdata    (rdata)
    );

    // Upper address bits must be clear; out-of-range fetches read as NOP
    assign hit        = ({1'b0, mem_request} < 7'(DEPTH));
    assign mem_data   = (state_q == SERVE && hit) ? rdata : 6'd0;
    assign load_full  = full_q;
    assign load_count = count_q;

endmodule
